// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } div_state_e;

  localparam logic [31:0] IntMin = 32'h8000_0000;
  localparam logic [31:0] NegOne = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             StartE;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       DivControlE;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] DivResult;
  logic             DivByZero;

  modport master (
    output StartE, A, B, DivControlE,
    input  Busy, Done, DivResult, DivByZero
  );

  modport slave (
    input  StartE, A, B, DivControlE,
    output Busy, Done, DivResult, DivByZero
  );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, msb_i};
  // rem_i < divisor_i keeps the true difference inside (-2^WIDTH, 2^WIDTH), so the
  // top bit of a WIDTH+1-bit subtract is a correct borrow.
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: restoring divide on magnitudes plus sign fixup.
// Optional ITER_DIVIDER_EARLY_OUT_EN skips the dividend's leading zeros.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          CLK,
  input logic          RST,
  iter_divider_if.slave bus
);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = '1;

  div_state_e       state_q;
  div_op_e          op_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qneg_q, rneg_q, busy_q, done_q, dbz_q;

  div_op_e          op_in;
  logic             sgn_in;
  logic [WIDTH-1:0] mag_a, mag_b, dvd_init;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] step_rem, quo_fix, rem_fix, res_fix;
  logic             step_qbit;

  assign op_in  = div_op_e'(bus.DivControlE);
  assign sgn_in = is_signed_op(op_in);
  assign mag_a  = (sgn_in && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign mag_b  = (sgn_in && bus.B[WIDTH-1]) ? -bus.B : bus.B;

`ifdef ITER_DIVIDER_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  logic             lz_done;

  always_comb begin
    lz      = '0;
    lz_done = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lz_done) begin
        if (mag_a[i]) lz_done = 1'b1;
        else          lz      = lz + CNT_W'(1);
      end
    end
  end

  // A zero dividend still runs one step so the datapath stays uniform.
  assign dvd_init = mag_a << lz;
  assign cnt_init = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : CNT_W'(WIDTH) - lz;
`else
  assign dvd_init = mag_a;
  assign cnt_init = CNT_W'(WIDTH);
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .msb_i    (quo_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

  // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;
  assign res_fix = (op_q == OpRem || op_q == OpRemu) ? rem_fix : quo_fix;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      op_q    <= OpDiv;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.StartE) begin
            busy_q <= 1'b1;
            op_q   <= op_in;
            qneg_q <= sgn_in & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rneg_q <= sgn_in & bus.A[WIDTH-1];
            quo_q  <= dvd_init;
            dvs_q  <= mag_b;
            rem_q  <= '0;
            cnt_q  <= cnt_init;
            if (bus.B == '0) begin
              res_q   <= bus.DivControlE[1] ? bus.A : AllOnes;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (sgn_in && bus.A == MinVal && bus.B == AllOnes) begin
              res_q   <= bus.DivControlE[1] ? '0 : MinVal;
              dbz_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_qbit};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= StFixup;
        end
        StFixup: begin
          res_q   <= res_fix;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivResult = res_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle RV32M divide/remainder unit; execute-stage companion to the single-cycle ALU.
- Handles the operations the ALU cannot complete combinationally: DIV, DIVU, REM and REMU.
- Radix-2 restoring algorithm on operand magnitudes, followed by a sign-fixup step.
- Start/busy/done handshake lets the hazard unit stall the pipeline while the unit is busy.

Parameters:
- WIDTH, 32: operand and result width.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- StartE  input  1  request. Sampled only in IDLE.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- DivControlE  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Busy  output  1  high from the cycle after a start is accepted until the cycle Done is high, inclusive.
- Done  output  1  single-cycle pulse. DivResult is valid in that cycle.
- DivResult  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU). Held until the next Done.
- DivByZero  output  1  high with Done when B == 0. Held with DivResult.

Behaviour:
- Reset (async, RST low): state IDLE; Busy 0; Done 0; DivResult 0; DivByZero 0; counter 0. Reset mid-operation abandons the operation with no residue; the first start after reset behaves normally.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, StartE = 1 at edge k:
  - Latch the op.
  - Signed ops: latch |A| and |B|, plus the quotient sign (A[31]^B[31]) and remainder sign (A[31]).
  - Unsigned ops: latch A and B unchanged.
  - Clear the partial remainder, load the counter with WIDTH, go to CALC.
- Special cases, checked at edge k, skip straight to DONE with the result registered at edge k (Done at cycle k+1):
  - B == 0: quotient = all ones (0xFFFFFFFF), remainder = A, DivByZero = 1.
  - Signed op with A = 0x80000000 and B = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC, one step per cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Trial subtract the divisor using a WIDTH+1-bit subtract; the borrow is the sign bit.
  - If no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; leave for FIXUP when the counter reaches 1 at the edge.
  - Normal latency: start edge k, 32 CALC edges (k+1..k+32), FIXUP edge k+33, Done high in cycle k+34.
- FIXUP: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed ops only). Register the selected value into DivResult, set Done, go to DONE.
- DONE: Done = 1 for exactly this cycle, then return to IDLE. A StartE seen in the DONE cycle is ignored; the next start is accepted in IDLE the following cycle.
- StartE while Busy: ignored, with no effect on state or operands.
- Operand ports are not sampled after edge k.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_OUT_EN.
- Defined: at start, count leading zeros of the dividend magnitude (lz). Pre-shift the dividend left by lz and load the counter with max(1, WIDTH-lz). Normal latency becomes iterations + 2. Results are bit-identical to the fixed-latency build.
- Undefined: no leading-zero logic; fixed 34-cycle latency for all non-special operands.

Decomposition:
- Package div_pkg:
  - DivControl encodings: DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11.
  - State encoding: IDLE, CALC, FIXUP, DONE.
  - Special constants: INT_MIN = 0x80000000, NEG_ONE = 0xFFFFFFFF.
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once; the FSM/datapath register stays in iter_divider.

Test Plan:
- DIVU, A = 100, B = 7, start at edge 0 -> Busy high cycles 1..34, Done pulses in cycle 34, DivResult = 14, DivByZero = 0.
- DIV, A = -100 (0xFFFFFF9C), B = 7 -> DivResult = 0xFFFFFFF2 (-14). REM with the same operands -> 0xFFFFFFFE (-2).
- REMU, A = 5, B = 0 -> Done in cycle 1, DivResult = 5, DivByZero = 1. DIV, A = 5, B = 0 -> DivResult = 0xFFFFFFFF.
- DIV, A = 0x80000000, B = 0xFFFFFFFF -> Done in cycle 1, DivResult = 0x80000000. REM with the same operands -> 0.
- DIVU, A = 1000, B = 3: pulse RST low at cycle 10 -> all outputs 0 immediately. Second StartE at cycle 5 while busy has no effect. After reset, a new DIVU 9/3 -> 3.
- With ITER_DIVIDER_EARLY_OUT_EN defined, DIVU A = 0x0000000F, B = 2 -> 4 iterations, Done in cycle 6, DivResult = 7. The same test with the macro undefined -> Done in cycle 34.
